// File: rtl/nib2byte_merge_pkg.sv
// Shared constants and FSM encoding for the nibble-plane to byte reassembly path.
// Also used by the saturating adder side so both agree on lane geometry and the saturation code.
package nib2byte_merge_pkg;

    localparam int LANES  = 32;
    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 6;

    localparam logic [BYTE_W-1:0] SAT_CODE = 8'hFF;

    typedef enum logic [1:0] {
        S_LO,
        S_HI,
        S_OUT0,
        S_OUT1
    } state_t;

endpackage

// File: rtl/nib2byte_merge_lane.sv
// One lane of the merge: concatenates a high and a low nibble into a byte.
// It also flags whether that byte equals the saturation code.
module nib_merge_lane
    import nib2byte_merge_pkg::*;
#(
    parameter logic [7:0] SAT_CODE = nib2byte_merge_pkg::SAT_CODE
) (
    input  logic [NIB_W-1:0]  hi,
    input  logic [NIB_W-1:0]  lo,
    output logic [BYTE_W-1:0] merged,
    output logic              sat
);

    assign merged = {hi, lo};
    assign sat    = ({hi, lo} == SAT_CODE);

endmodule

// File: rtl/nib2byte_merge.sv
// Reassembles two 128-bit nibble planes into 32 int8 lanes and streams them out as two 128-bit beats.
// Each output vector carries a count of lanes that hold the saturation code.
module nib2byte_merge
    import nib2byte_merge_pkg::*;
#(
    parameter int         LANES    = nib2byte_merge_pkg::LANES,
    parameter logic [7:0] SAT_CODE = nib2byte_merge_pkg::SAT_CODE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  out_sat_cnt,
    output logic              err_seq
);

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0]        lo_reg;
    logic [LANES*BYTE_W-1:0]  res_reg;
    logic [CNT_W-1:0]         sat_reg;

    logic                     lo_take;
    logic                     hi_take;
    logic [LANES*BYTE_W-1:0]  merged;
    logic [LANES-1:0]         sat_flag;

    logic [CNT_W-1:0]         sum_l1 [LANES/2];
    logic [CNT_W-1:0]         sum_l2 [LANES/4];
    logic [CNT_W-1:0]         sum_l3 [LANES/8];
    logic [CNT_W-1:0]         sum_l4 [LANES/16];
    logic [CNT_W-1:0]         sat_sum;

    // The high plane arrives live on in_data while the low plane waits in lo_reg.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        nib_merge_lane #(
            .SAT_CODE (SAT_CODE)
        ) u_lane (
            .hi     (in_data[NIB_W*i +: NIB_W]),
            .lo     (lo_reg[NIB_W*i +: NIB_W]),
            .merged (merged[BYTE_W*i +: BYTE_W]),
            .sat    (sat_flag[i])
        );
    end

    always_comb begin
        for (int i = 0; i < LANES/2; i++) begin
            sum_l1[i] = CNT_W'(sat_flag[2*i]) + CNT_W'(sat_flag[2*i+1]);
        end
        for (int i = 0; i < LANES/4; i++) begin
            sum_l2[i] = sum_l1[2*i] + sum_l1[2*i+1];
        end
        for (int i = 0; i < LANES/8; i++) begin
            sum_l3[i] = sum_l2[2*i] + sum_l2[2*i+1];
        end
        for (int i = 0; i < LANES/16; i++) begin
            sum_l4[i] = sum_l3[2*i] + sum_l3[2*i+1];
        end
        sat_sum = sum_l4[0] + sum_l4[1];
    end

    // clr overrides every handshake, so no beat is taken and no output transfer happens in that cycle.
    always_comb begin
        state_nxt = state;
        lo_take   = 1'b0;
        hi_take   = 1'b0;
        if (clr) begin
            state_nxt = S_LO;
        end else begin
            case (state)
                S_LO: begin
                    if (in_valid) begin
                        lo_take   = 1'b1;
                        state_nxt = S_HI;
                    end
                end
                S_HI: begin
                    if (in_valid) begin
                        hi_take   = 1'b1;
                        state_nxt = S_OUT0;
                    end
                end
                S_OUT0: begin
                    if (out_ready) begin
                        state_nxt = S_OUT1;
                    end
                end
                S_OUT1: begin
                    if (out_ready) begin
                        state_nxt = S_LO;
                    end
                end
                default: begin
                    state_nxt = S_LO;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_LO;
            lo_reg  <= '0;
            res_reg <= '0;
            sat_reg <= '0;
            err_seq <= 1'b0;
        end else begin
            state <= state_nxt;
            if (lo_take) begin
                lo_reg <= in_data;
            end
            if (hi_take) begin
                res_reg <= merged;
                sat_reg <= sat_sum;
            end
            if (clr && (state != S_LO)) begin
                err_seq <= 1'b1;
            end
        end
    end

    // Outputs decode only from state and registers, so they hold steady under backpressure.
    assign in_ready    = (state == S_LO) || (state == S_HI);
    assign out_valid   = (state == S_OUT0) || (state == S_OUT1);
    assign out_last    = (state == S_OUT1);
    assign out_data    = (state == S_OUT1) ? res_reg[2*DATA_W-1:DATA_W] : res_reg[DATA_W-1:0];
    assign out_sat_cnt = sat_reg;

endmodule

// File: tb/tb_nib2byte_merge.sv
// Self-checking bench for nib2byte_merge.
// It runs directed table vectors, multi-cycle corner sequences, and random streaming against a reference model.
module tb_nib2byte_merge;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_last;
    logic [5:0]   out_sat_cnt;
    logic         err_seq;

    int n_checks = 0;
    int n_pass   = 0;
    int xfer_cnt = 0;

    typedef struct {
        logic [127:0] lo;
        logic [127:0] hi;
        logic [127:0] exp0;
        logic [127:0] exp1;
        logic [5:0]   exp_sat;
    } vec_t;

    typedef struct {
        logic [127:0] b0;
        logic [127:0] b1;
        int           sat;
    } exp_t;

    exp_t exp_q[$];

    nib2byte_merge dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_sat_cnt (out_sat_cnt),
        .err_seq     (err_seq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Byte i is hi_nibble*16 + lo_nibble; saturated lanes are bytes equal to 255.
    function automatic exp_t model(input logic [127:0] lo, input logic [127:0] hi);
        exp_t         e;
        logic [255:0] full;
        int           sat;
        full = '0;
        sat  = 0;
        for (int i = 0; i < 32; i++) begin
            int v;
            v = int'(hi[4*i +: 4]) * 16 + int'(lo[4*i +: 4]);
            if (v == 255) sat++;
            full[8*i +: 8] = 8'(v);
        end
        e.b0  = full[127:0];
        e.b1  = full[255:128];
        e.sat = sat;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("[TB] FAIL %s: got timeout, want handshake", name);
    endtask

    // Entered and left at a negedge; the handshake happens on the posedge in between.
    task automatic send_beat(input logic [127:0] d, input string name, input bit rnd);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = d;
            if (in_valid && in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) timeout(name);
    endtask

    task automatic applyStimulus(input logic [127:0] lo, input logic [127:0] hi);
        send_beat(lo, "lo beat", 1'b0);
        send_beat(hi, "hi beat", 1'b0);
    endtask

    task automatic receive_beat(output logic [127:0] d, output logic l, output logic [5:0] s,
                                input string name, input bit rnd);
        bit ok;
        ok = 1'b0;
        d  = '0;
        l  = 1'b0;
        s  = '0;
        for (int c = 0; c < 400; c++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                d = out_data;
                l = out_last;
                s = out_sat_cnt;
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (!ok) timeout(name);
    endtask

    vec_t         tbl[5];
    exp_t         e;
    logic [127:0] d0, d1;
    logic         l0, l1;
    logic [5:0]   s0, s1;
    logic         stable;
    int           x0;

    initial begin
        tbl[0] = '{128'h0123456789ABCDEF0123456789ABCDEF, {32{4'hA}},
                   128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 6'd0};
        tbl[1] = '{{32{4'hF}}, {32{4'hF}}, {16{8'hFF}}, {16{8'hFF}}, 6'd32};
        tbl[2] = '{128'hF000_0000_0000_0000_0000_0000_00F0_000F, 128'hF000_0000_0000_0000_0000_0000_00F0_000F,
                   128'h0000_0000_0000_0000_0000_FF00_0000_00FF, 128'hFF00_0000_0000_0000_0000_0000_0000_0000, 6'd3};
        tbl[3] = '{{32{4'hE}}, {32{4'hF}}, {16{8'hFE}}, {16{8'hFE}}, 6'd0};
        tbl[4] = '{{32{4'hF}}, {32{4'h7}}, {16{8'h7F}}, {16{8'h7F}}, 6'd0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset in_ready", 128'(in_ready), 128'd1);
        checkOutput("reset out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset out_last", 128'(out_last), 128'd0);
        checkOutput("reset out_data", out_data, 128'd0);
        checkOutput("reset out_sat_cnt", 128'(out_sat_cnt), 128'd0);
        checkOutput("reset err_seq", 128'(err_seq), 128'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(tbl[i].lo, tbl[i].hi);
            checkOutput($sformatf("vec%0d latency out_valid", i), 128'(out_valid), 128'd1);
            checkOutput($sformatf("vec%0d in_ready busy", i), 128'(in_ready), 128'd0);
            receive_beat(d0, l0, s0, "table beat0", 1'b0);
            receive_beat(d1, l1, s1, "table beat1", 1'b0);
            checkOutput($sformatf("vec%0d beat0 data", i), d0, tbl[i].exp0);
            checkOutput($sformatf("vec%0d beat1 data", i), d1, tbl[i].exp1);
            checkOutput($sformatf("vec%0d beat0 last", i), 128'(l0), 128'd0);
            checkOutput($sformatf("vec%0d beat1 last", i), 128'(l1), 128'd1);
            checkOutput($sformatf("vec%0d beat0 sat", i), 128'(s0), 128'(tbl[i].exp_sat));
            checkOutput($sformatf("vec%0d beat1 sat", i), 128'(s1), 128'(tbl[i].exp_sat));
        end

        // Backpressure: 5 stalled cycles on beat 0, 3 on beat 1.
        e  = model(128'h89ABCDEF_01234567_FEDCBA98_76543210, 128'hFFFF0000_F0F0F0F0_12345678_FFFFFFFF);
        x0 = xfer_cnt;
        applyStimulus(128'h89ABCDEF_01234567_FEDCBA98_76543210, 128'hFFFF0000_F0F0F0F0_12345678_FFFFFFFF);
        d0 = out_data;
        s0 = out_sat_cnt;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_data !== d0 || out_last !== 1'b0 || out_sat_cnt !== s0 || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        checkOutput("bp beat0 stable", 128'(stable), 128'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        d1 = out_data;
        s1 = out_sat_cnt;
        stable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_data !== d1 || out_last !== 1'b1 || out_sat_cnt !== s1 || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        checkOutput("bp beat1 stable", 128'(stable), 128'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp beat0 data", d0, e.b0);
        checkOutput("bp beat1 data", d1, e.b1);
        checkOutput("bp sat", 128'(s1), 128'(e.sat));
        checkOutput("bp transfer count", 128'(xfer_cnt - x0), 128'd2);
        checkOutput("bp idle after", 128'(out_valid), 128'd0);

        // Abort: clr coincides with a valid high plane, which must be dropped.
        send_beat(128'h11111111_11111111_11111111_11111111, "abort lo", 1'b0);
        in_valid = 1'b1;
        in_data  = {32{4'hC}};
        clr      = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort err_seq", 128'(err_seq), 128'd1);
        checkOutput("abort in_ready", 128'(in_ready), 128'd1);
        checkOutput("abort out_valid", 128'(out_valid), 128'd0);
        e = model(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, {32{4'h3}});
        applyStimulus(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, {32{4'h3}});
        receive_beat(d0, l0, s0, "abort beat0", 1'b0);
        receive_beat(d1, l1, s1, "abort beat1", 1'b0);
        checkOutput("abort next beat0", d0, e.b0);
        checkOutput("abort next beat1", d1, e.b1);

        // Reset while beat 1 is presented.
        applyStimulus({32{4'hF}}, {32{4'hF}});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("rst pre out_last", 128'(out_last), 128'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst mid out_valid", 128'(out_valid), 128'd0);
        checkOutput("rst mid in_ready", 128'(in_ready), 128'd1);
        checkOutput("rst mid err_seq", 128'(err_seq), 128'd0);
        checkOutput("rst mid sat_cnt", 128'(out_sat_cnt), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Random streaming with 50% valid and ready.
        fork
            begin
                for (int v = 0; v < 8; v++) begin
                    logic [127:0] lo, hi;
                    for (int l = 0; l < 32; l++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            lo[4*l +: 4] = 4'hF;
                            hi[4*l +: 4] = 4'hF;
                        end else begin
                            lo[4*l +: 4] = 4'($urandom);
                            hi[4*l +: 4] = 4'($urandom);
                        end
                    end
                    exp_q.push_back(model(lo, hi));
                    send_beat(lo, "stream lo", 1'b1);
                    send_beat(hi, "stream hi", 1'b1);
                end
            end
            begin
                for (int v = 0; v < 8; v++) begin
                    logic [127:0] r0, r1;
                    logic         rl0, rl1;
                    logic [5:0]   rs0, rs1;
                    exp_t         x;
                    receive_beat(r0, rl0, rs0, "stream beat0", 1'b1);
                    receive_beat(r1, rl1, rs1, "stream beat1", 1'b1);
                    if (exp_q.size() == 0) begin
                        timeout("stream scoreboard empty");
                    end else begin
                        x = exp_q.pop_front();
                        checkOutput($sformatf("stream%0d beat0", v), r0, x.b0);
                        checkOutput($sformatf("stream%0d beat1", v), r1, x.b1);
                        checkOutput($sformatf("stream%0d last", v), 128'({rl0, rl1}), 128'd1);
                        checkOutput($sformatf("stream%0d sat0", v), 128'(rs0), 128'(x.sat));
                        checkOutput($sformatf("stream%0d sat1", v), 128'(rs1), 128'(x.sat));
                    end
                end
            end
        join
        checkOutput("stream leftovers", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
